// File: rtl/aes_core_arbiter_if.sv
// Requester-side bus of aes_core_arbiter: per-requester operand handshake
// plus the shared result bus with per-requester valid/ready.
interface aes_core_arbiter_if #(
    parameter int unsigned N_REQ = 2
);
    logic [N_REQ-1:0]        req_valid_i;
    logic [N_REQ-1:0]        req_ready_o;
    logic [N_REQ-1:0][127:0] req_text_i;
    logic [N_REQ-1:0][127:0] req_key_i;
    logic [N_REQ-1:0]        rsp_valid_o;
    logic [N_REQ-1:0]        rsp_ready_i;
    logic [127:0]            rsp_data_o;

    modport master (
        output req_valid_i, req_text_i, req_key_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o
    );

    modport slave (
        input  req_valid_i, req_text_i, req_key_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_data_o
    );
endinterface

// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter/sequencer sharing one AES core between N_REQ requesters:
// owns the core ld/done protocol, holds operands, routes results, watchdog.
module aes_core_arbiter #(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned TIMEOUT = 64,
    localparam int unsigned GW     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int unsigned WW     = $clog2(TIMEOUT) + 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                enable_i,
    aes_core_arbiter_if.slave   bus,
    output logic                core_ld_o,
    output logic [127:0]        core_text_o,
    output logic [127:0]        core_key_o,
    input  logic                core_done_i,
    input  logic [127:0]        core_text_i,
    output logic                busy_o,
    output logic [GW-1:0]       grant_o,
    output logic                err_o
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        HOLD
    } state_e;

    state_e        state_q, state_d;
    logic [GW-1:0] last_q;
    logic [GW-1:0] grant_q;
    logic [127:0]  text_q;
    logic [127:0]  key_q;
    logic [127:0]  result_q;
    logic [WW-1:0] wdog_q;
    logic          err_q;

    logic          win_found;
    logic [GW-1:0] win_idx;
    logic [GW-1:0] cand;
    logic          accept;
    logic          timeout;
    logic          rsp_done;

    // Round-robin search starting one past the last owner, wrapping modulo N_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = GW'((32'(last_q) + i) % N_REQ);
            if (!win_found && bus.req_valid_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        bus.req_ready_o = '0;
        bus.rsp_valid_o = '0;
        core_ld_o       = 1'b0;
        accept          = 1'b0;
        timeout         = 1'b0;
        rsp_done        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable_i && win_found && !clear_i) begin
                    bus.req_ready_o[win_idx] = 1'b1;
                    accept                   = 1'b1;
                    state_d                  = LOAD;
                end
            end
            LOAD: begin
                core_ld_o = 1'b1;
                state_d   = RUN;
            end
            RUN: begin
                // A done arriving in the same cycle as the trip point wins.
                if (core_done_i) begin
                    state_d = HOLD;
                end else if (wdog_q == WW'(TIMEOUT - 2)) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            HOLD: begin
                bus.rsp_valid_o[grant_q] = 1'b1;
                if (bus.rsp_ready_i[grant_q]) begin
                    rsp_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clear_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q   <= GW'(N_REQ - 1);
            grant_q  <= '0;
            text_q   <= '0;
            key_q    <= '0;
            result_q <= '0;
            wdog_q   <= '0;
            err_q    <= 1'b0;
        end else if (clear_i) begin
            last_q   <= GW'(N_REQ - 1);
            grant_q  <= '0;
            text_q   <= '0;
            key_q    <= '0;
            result_q <= '0;
            wdog_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                text_q  <= bus.req_text_i[win_idx];
                key_q   <= bus.req_key_i[win_idx];
                grant_q <= win_idx;
            end
            if (state_q == LOAD) begin
                wdog_q <= '0;
            end else if (state_q == RUN) begin
                wdog_q <= wdog_q + 1'b1;
            end
            if (state_q == RUN && core_done_i) begin
                result_q <= core_text_i;
            end
            if (timeout) begin
                err_q  <= 1'b1;
                last_q <= grant_q;
            end
            if (rsp_done) begin
                last_q <= grant_q;
            end
        end
    end

    assign core_text_o    = text_q;
    assign core_key_o     = key_q;
    assign bus.rsp_data_o = result_q;
    assign busy_o         = (state_q != IDLE);
    assign grant_o        = grant_q;
    assign err_o          = err_q;

    a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(bus.req_ready_o));
    a_rsp_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(bus.rsp_valid_o));
    a_operands_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == RUN && !clear_i) |=> ($stable(text_q) && $stable(key_q)));
    a_rsp_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == HOLD && !bus.rsp_ready_i[grant_q] && !clear_i) |=> state_q == HOLD);

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed bench for aes_core_arbiter: vector table of jobs plus hand-written
// backpressure, watchdog, clear, enable and async-reset sequences.
module tb_aes_core_arbiter;

    localparam int unsigned K       = 5;
    localparam int unsigned TIMEOUT = 16;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clear;
    logic         enable;
    logic         core_ld;
    logic [127:0] core_text;
    logic [127:0] core_key;
    logic         core_done;
    logic [127:0] core_ct;
    logic         busy;
    logic         grant;
    logic         err;

    int unsigned total = 0;
    int unsigned bad   = 0;

    aes_core_arbiter_if #(.N_REQ(2)) bus ();

    aes_core_arbiter #(.N_REQ(2), .TIMEOUT(TIMEOUT)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clear_i     (clear),
        .enable_i    (enable),
        .bus         (bus),
        .core_ld_o   (core_ld),
        .core_text_o (core_text),
        .core_key_o  (core_key),
        .core_done_i (core_done),
        .core_text_i (core_ct),
        .busy_o      (busy),
        .grant_o     (grant),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    // Stand-in core: FIPS-197 vector gives the real ciphertext, anything else text^key.
    function automatic logic [127:0] core_fn(input logic [127:0] t, input logic [127:0] k);
        if (t == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
        return t ^ k;
    endfunction

    logic         never_done;
    logic         m_busy;
    logic [3:0]   m_cnt;
    logic [127:0] m_t, m_k;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy    <= 1'b0;
            m_cnt     <= '0;
            m_t       <= '0;
            m_k       <= '0;
            core_done <= 1'b0;
            core_ct   <= '0;
        end else begin
            core_done <= 1'b0;
            if (core_ld && !never_done) begin
                m_busy <= 1'b1;
                m_cnt  <= 4'(K - 1);
                m_t    <= core_text;
                m_k    <= core_key;
            end else if (m_busy) begin
                if (m_cnt == 4'd1) begin
                    core_done <= 1'b1;
                    core_ct   <= core_fn(m_t, m_k);
                    m_busy    <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 4'd1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] oh(input int unsigned g);
        logic [1:0] r;
        r = '0;
        r[g] = 1'b1;
        return r;
    endfunction

    // Entered at a negedge with req_valid/text/key already driven and the DUT in IDLE.
    task automatic run_job(input string tag, input int unsigned g, input logic [127:0] exp_d);
        int unsigned n;
        logic [127:0] exp_t, exp_k;
        exp_t = bus.req_text_i[g];
        exp_k = bus.req_key_i[g];
        #1;
        chk({tag, "_ready"}, 128'(bus.req_ready_o), 128'(oh(g)));
        @(negedge clk);
        bus.req_valid_i = '0;
        chk({tag, "_ld"}, 128'(core_ld), 128'd1);
        chk({tag, "_grant"}, 128'(grant), 128'(g));
        chk({tag, "_optext"}, core_text, exp_t);
        chk({tag, "_opkey"}, core_key, exp_k);
        n = 0;
        while (bus.rsp_valid_o == 2'b00 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 128'(n), 128'(K + 1));
        chk({tag, "_rspv"}, 128'(bus.rsp_valid_o), 128'(oh(g)));
        chk({tag, "_data"}, bus.rsp_data_o, exp_d);
        bus.rsp_ready_i = oh(g);
        @(negedge clk);
        bus.rsp_ready_i = '0;
        chk({tag, "_idle"}, 128'(busy), 128'd0);
        chk({tag, "_rspv_low"}, 128'(bus.rsp_valid_o), 128'd0);
    endtask

    typedef struct {
        logic [1:0]   mask;
        logic [127:0] t0, k0, t1, k1;
        int unsigned  g;
        logic [127:0] exp;
    } vec_t;

    vec_t vec [6];

    initial begin
        #400000;
        $display("FAIL tb_timeout: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        int unsigned n;
        logic seen;

        vec[0] = '{2'b01, FIPS_PT, FIPS_KEY, 128'h0, 128'h0, 0, FIPS_CT};
        vec[1] = '{2'b10, 128'h0, 128'h0, {32{4'hf}}, {16{8'h0f}}, 1, {16{8'hf0}}};
        vec[2] = '{2'b11, {32{4'h1}}, {32{4'h2}}, {8{16'hcafe}}, 128'h0, 0, {32{4'h3}}};
        vec[3] = '{2'b11, {32{4'h7}}, 128'h0, {32{4'ha}}, {32{4'h5}}, 1, {32{4'hf}}};
        vec[4] = '{2'b11, {2{64'h0123456789abcdef}}, 128'h0, {32{4'h9}}, 128'h1, 0,
                   {2{64'h0123456789abcdef}}};
        vec[5] = '{2'b11, {32{4'hc}}, {32{4'h3}}, 128'h0, {4{32'hdeadbeef}}, 1,
                   {4{32'hdeadbeef}}};

        rst_n           = 1'b0;
        clear           = 1'b0;
        enable          = 1'b0;
        never_done      = 1'b0;
        bus.req_valid_i = '0;
        bus.req_text_i  = '0;
        bus.req_key_i   = '0;
        bus.rsp_ready_i = '0;
        repeat (3) @(negedge clk);

        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_ld", 128'(core_ld), 128'd0);
        chk("rst_grant", 128'(grant), 128'd0);
        chk("rst_err", 128'(err), 128'd0);
        chk("rst_rspv", 128'(bus.rsp_valid_o), 128'd0);
        chk("rst_optext", core_text, 128'd0);
        chk("rst_data", bus.rsp_data_o, 128'd0);

        rst_n  = 1'b1;
        enable = 1'b1;
        @(negedge clk);

        // Single job, then solo req1, then contention 0,1,0,1.
        for (int i = 0; i < 6; i++) begin
            bus.req_valid_i   = vec[i].mask;
            bus.req_text_i[0] = vec[i].t0;
            bus.req_key_i[0]  = vec[i].k0;
            bus.req_text_i[1] = vec[i].t1;
            bus.req_key_i[1]  = vec[i].k1;
            run_job($sformatf("vec%0d", i), vec[i].g, vec[i].exp);
        end

        // Backpressure on requester 1.
        bus.req_text_i[1] = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        bus.req_key_i[1]  = 128'h0;
        bus.req_valid_i   = 2'b10;
        #1;
        chk("bp_ready", 128'(bus.req_ready_o), 128'(2'b10));
        @(negedge clk);
        bus.req_valid_i = '0;
        n = 0;
        while (bus.rsp_valid_o == 2'b00 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("bp_latency", 128'(n), 128'(K + 1));
        bus.rsp_ready_i   = 2'b01;
        bus.req_text_i[0] = {32{4'h5}};
        bus.req_key_i[0]  = {32{4'ha}};
        bus.req_valid_i   = 2'b01;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("bp_rspv", 128'(bus.rsp_valid_o), 128'(2'b10));
            chk("bp_data", bus.rsp_data_o, 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0);
            chk("bp_noready", 128'(bus.req_ready_o), 128'd0);
            @(negedge clk);
        end
        bus.rsp_ready_i = 2'b10;
        #1;
        chk("bp_hs_noready", 128'(bus.req_ready_o), 128'd0);
        @(negedge clk);
        bus.rsp_ready_i = '0;
        #1;
        chk("bp_next_grant", 128'(bus.req_ready_o), 128'(2'b01));
        run_job("bp_next", 0, {32{4'hf}});

        // Watchdog: core never completes.
        never_done        = 1'b1;
        bus.req_text_i[0] = {32{4'h4}};
        bus.req_key_i[0]  = {32{4'h1}};
        bus.req_valid_i   = 2'b01;
        #1;
        chk("wd_ready", 128'(bus.req_ready_o), 128'(2'b01));
        @(negedge clk);
        bus.req_valid_i = '0;
        chk("wd_ld", 128'(core_ld), 128'd1);
        n    = 0;
        seen = 1'b0;
        while (!err && n < 200) begin
            @(negedge clk);
            n++;
            if (bus.rsp_valid_o != 2'b00) seen = 1'b1;
        end
        chk("wd_err_time", 128'(n), 128'(TIMEOUT));
        chk("wd_idle", 128'(busy), 128'd0);
        chk("wd_no_rsp", 128'(seen), 128'd0);
        never_done        = 1'b0;
        bus.req_text_i[0] = {32{4'h6}};
        bus.req_key_i[0]  = {32{4'h9}};
        bus.req_valid_i   = 2'b01;
        run_job("wd_next", 0, {32{4'hf}});
        chk("wd_err_sticky", 128'(err), 128'd1);

        // Clear during RUN; the core's done arrives afterwards and must be ignored.
        bus.req_text_i[1] = {32{4'hb}};
        bus.req_key_i[1]  = {32{4'h4}};
        bus.req_valid_i   = 2'b10;
        #1;
        chk("clr_ready", 128'(bus.req_ready_o), 128'(2'b10));
        @(negedge clk);
        bus.req_valid_i = '0;
        @(negedge clk);
        chk("clr_in_run", 128'(busy), 128'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_idle", 128'(busy), 128'd0);
        chk("clr_err", 128'(err), 128'd0);
        chk("clr_optext", core_text, 128'd0);
        chk("clr_opkey", core_key, 128'd0);
        chk("clr_result", bus.rsp_data_o, 128'd0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("clr_no_rsp", 128'(bus.rsp_valid_o), 128'd0);
            chk("clr_stay_idle", 128'(busy), 128'd0);
        end
        bus.req_text_i[0] = {16{8'h12}};
        bus.req_key_i[0]  = {16{8'h21}};
        bus.req_valid_i   = 2'b11;
        run_job("clr_next", 0, {32{4'h3}});

        // Enable low blocks grants; dropping it mid-job does not abort.
        enable            = 1'b0;
        bus.req_text_i[0] = {16{8'h80}};
        bus.req_key_i[0]  = {16{8'h01}};
        bus.req_valid_i   = 2'b01;
        for (int c = 0; c < 20; c++) begin
            #1;
            chk("en_noready", 128'(bus.req_ready_o), 128'd0);
            chk("en_idle", 128'(busy), 128'd0);
            @(negedge clk);
        end
        enable = 1'b1;
        #1;
        chk("en_ready", 128'(bus.req_ready_o), 128'(2'b01));
        @(negedge clk);
        bus.req_valid_i = '0;
        @(negedge clk);
        enable = 1'b0;
        n = 0;
        while (bus.rsp_valid_o == 2'b00 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("en_rspv", 128'(bus.rsp_valid_o), 128'(2'b01));
        chk("en_data", bus.rsp_data_o, {16{8'h81}});
        bus.rsp_ready_i = 2'b01;
        @(negedge clk);
        bus.rsp_ready_i = '0;
        bus.req_valid_i = 2'b10;
        #1;
        chk("en_done_idle", 128'(busy), 128'd0);
        chk("en_still_blocked", 128'(bus.req_ready_o), 128'd0);
        @(negedge clk);
        enable = 1'b1;

        // Asynchronous reset in the middle of RUN.
        bus.req_text_i[1] = {16{8'h5a}};
        bus.req_key_i[1]  = {16{8'h0f}};
        #1;
        chk("ar_ready", 128'(bus.req_ready_o), 128'(2'b10));
        @(negedge clk);
        bus.req_valid_i = '0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_busy", 128'(busy), 128'd0);
        chk("ar_grant", 128'(grant), 128'd0);
        chk("ar_optext", core_text, 128'd0);
        chk("ar_ld", 128'(core_ld), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.req_text_i[0] = {32{4'he}};
        bus.req_key_i[0]  = {32{4'h1}};
        bus.req_valid_i   = 2'b11;
        run_job("ar_next", 0, {32{4'hf}});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
